// File: rtl/rca_lsq_port.sv
// rca_lsq_port: memory-side load/store responder for an RCA operation unit slot.
// Requests are queued in order and issued one at a time to a word-addressed memory port.
// Loads return an extended byte/half/word with a one-cycle load_complete pulse.
// Stores retire silently once the memory acknowledges them.
//
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   addr, data, fn3, load, store request fields from the OU (fn3: B/H/W/BU/HU)
//   new_request                  request valid
//   lsq_full                     queue holds DEPTH entries (registered count only)
//   load_data, load_complete     extended load result and its qualifying pulse
//   mem_addr, mem_be, mem_wdata  word address, byte enables, lane-replicated store data
//   mem_rnw, mem_request         1 = read, request held until mem_ack
//   mem_ack, mem_rdata, mem_rvalid  memory handshake and read return
module rca_lsq_port #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned XLEN  = 32  // lane logic assumes 32-bit words
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] addr,
    input  logic [XLEN-1:0] data,
    input  logic [2:0]      fn3,
    input  logic            load,
    input  logic            store,
    input  logic            new_request,
    output logic            lsq_full,
    output logic [XLEN-1:0] load_data,
    output logic            load_complete,
    output logic [XLEN-1:0] mem_addr,
    output logic [3:0]      mem_be,
    output logic [XLEN-1:0] mem_wdata,
    output logic            mem_rnw,
    output logic            mem_request,
    input  logic            mem_ack,
    input  logic [XLEN-1:0] mem_rdata,
    input  logic            mem_rvalid
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

    state_e state_q, state_d;

    logic [XLEN-1:0] q_addr [DEPTH];
    logic [XLEN-1:0] q_data [DEPTH];
    logic [2:0]      q_fn3  [DEPTH];
    logic            q_load [DEPTH];

    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;

    logic            push, pop;
    logic [XLEN-1:0] head_addr, head_data;
    logic [2:0]      head_fn3;
    logic            head_load;

    logic [7:0]      rd_byte;
    logic [15:0]     rd_half;
    logic [XLEN-1:0] rd_ext;
    logic            load_done;

    logic [XLEN-1:0] load_data_q;
    logic            load_complete_q;

    // The load/store flag is carried by 'load' alone.
    logic unused_store;
    assign unused_store = store;

    assign head_addr = q_addr[rd_ptr_q];
    assign head_data = q_data[rd_ptr_q];
    assign head_fn3  = q_fn3[rd_ptr_q];
    assign head_load = q_load[rd_ptr_q];

    assign lsq_full = (count_q == CW'(DEPTH));

    // A retiring entry frees its slot in the same cycle, so a push is taken even when full
    // if a pop happens alongside it; count and lsq_full then stay put.
    assign pop  = ((state_q == StIssue) && mem_ack && !head_load) ||
                  ((state_q == StWait) && mem_rvalid);
    assign push = new_request && (!lsq_full || pop);

    assign load_done = (state_q == StWait) && mem_rvalid;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            state_q  <= StIdle;
        end else begin
            state_q <= state_d;
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Queue storage needs no reset: entries are only read below the registered count.
    always_ff @(posedge clk) begin
        if (push) begin
            q_addr[wr_ptr_q] <= addr;
            q_data[wr_ptr_q] <= data;
            q_fn3[wr_ptr_q]  <= fn3;
            q_load[wr_ptr_q] <= load;
        end
    end

    always_comb begin
        state_d     = state_q;
        mem_request = 1'b0;
        unique case (state_q)
            // A request arriving now is in the queue by the next cycle.
            StIdle: if ((count_q != '0) || new_request) state_d = StIssue;
            StIssue: begin
                mem_request = 1'b1;
                if (mem_ack) state_d = head_load ? StWait : StIdle;
            end
            StWait: if (mem_rvalid) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        mem_addr  = {head_addr[XLEN-1:2], 2'b00};
        mem_rnw   = head_load;
        mem_be    = 4'b1111;
        mem_wdata = head_data;
        if (!head_load) begin
            case (head_fn3[1:0])
                2'b00: begin
                    mem_be    = 4'b0001 << head_addr[1:0];
                    mem_wdata = {4{head_data[7:0]}};
                end
                2'b01: begin
                    mem_be    = 4'b0011 << {head_addr[1], 1'b0};
                    mem_wdata = {2{head_data[15:0]}};
                end
                default: begin
                    mem_be    = 4'b1111;
                    mem_wdata = head_data;
                end
            endcase
        end
    end

    always_comb begin
        rd_byte = mem_rdata[{head_addr[1:0], 3'b000} +: 8];
        rd_half = head_addr[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (head_fn3)
            3'b000:  rd_ext = {{24{rd_byte[7]}}, rd_byte};
            3'b100:  rd_ext = {24'b0, rd_byte};
            3'b001:  rd_ext = {{16{rd_half[15]}}, rd_half};
            3'b101:  rd_ext = {16'b0, rd_half};
            default: rd_ext = mem_rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            load_data_q     <= '0;
            load_complete_q <= 1'b0;
        end else begin
            load_complete_q <= load_done;
            if (load_done) load_data_q <= rd_ext;
        end
    end

    assign load_data     = load_data_q;
    assign load_complete = load_complete_q;

endmodule

// File: tb/tb_rca_lsq_port.sv
module tb_rca_lsq_port;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] addr, data;
    logic [2:0]  fn3;
    logic        load, store, new_request;
    logic        lsq_full;
    logic [31:0] load_data;
    logic        load_complete;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_rnw, mem_request;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        mem_rvalid;

    rca_lsq_port #(.DEPTH(4), .XLEN(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .addr         (addr),
        .data         (data),
        .fn3          (fn3),
        .load         (load),
        .store        (store),
        .new_request  (new_request),
        .lsq_full     (lsq_full),
        .load_data    (load_data),
        .load_complete(load_complete),
        .mem_addr     (mem_addr),
        .mem_be       (mem_be),
        .mem_wdata    (mem_wdata),
        .mem_rnw      (mem_rnw),
        .mem_request  (mem_request),
        .mem_ack      (mem_ack),
        .mem_rdata    (mem_rdata),
        .mem_rvalid   (mem_rvalid)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic        rnw;
    } txn_t;

    txn_t        tq[$];
    logic [31:0] lq[$];
    logic [31:0] mem_model [logic [31:0]];

    int n_checks = 0;
    int n_errors = 0;

    logic        ack_en;
    int          rv_extra;
    logic        rv_pending;
    int          rv_delay;
    logic [31:0] rv_data;
    txn_t        cur_t;
    logic [31:0] cur_ld;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_read(input logic [31:0] a);
        if (mem_model.exists(a)) return mem_model[a];
        return {a[15:0] ^ 16'hC3A5, a[15:0] + 16'h8E57};
    endfunction

    function automatic logic [31:0] ext_model(input logic [2:0] f, input logic [31:0] a,
                                              input logic [31:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[8*a[1:0] +: 8];
        h = a[1] ? w[31:16] : w[15:0];
        case (f)
            3'b000:  return {{24{b[7]}}, b};
            3'b100:  return {24'h0, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b101:  return {16'h0, h};
            default: return w;
        endcase
    endfunction

    // Drive one request for a cycle and queue what the memory port and load return should show.
    // Caller is at a negedge; returns at the following negedge.
    task automatic send(input logic ld, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] d, input logic expect_done, input logic wait_room);
        int   guard;
        txn_t t;
        guard = 0;
        while (wait_room && lsq_full && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 200) check("send_room_timeout", 32'(lsq_full), 32'd0);
        addr = a; data = d; fn3 = f; load = ld; store = !ld; new_request = 1'b1;
        t.addr = {a[31:2], 2'b00};
        t.rnw  = ld;
        if (ld) begin
            t.be = 4'b1111; t.wdata = d;
            if (expect_done) lq.push_back(ext_model(f, a, mem_read(t.addr)));
        end else begin
            case (f[1:0])
                2'b00:   begin t.be = 4'b0001 << a[1:0];        t.wdata = {4{d[7:0]}};  end
                2'b01:   begin t.be = 4'b0011 << {a[1], 1'b0};  t.wdata = {2{d[15:0]}}; end
                default: begin t.be = 4'b1111;                  t.wdata = d;            end
            endcase
        end
        tq.push_back(t);
        @(negedge clk);
        new_request = 1'b0;
    endtask

    task automatic wait_drain();
        int guard;
        guard = 0;
        while ((tq.size() != 0 || lq.size() != 0) && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        check("drain", 32'(tq.size() + lq.size()), 32'd0);
        repeat (2) @(negedge clk);
    endtask

    // Memory responder and scoreboard: acks requests, returns read data one cycle after the
    // ack (plus rv_extra), and checks every transaction and load result in order.
    initial begin
        mem_ack = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        rv_pending = 1'b0; rv_delay = 0; rv_data = '0;
        forever begin
            @(negedge clk);
            mem_rvalid = 1'b0;
            mem_rdata  = $urandom;
            if (load_complete) begin
                if (lq.size() == 0) check("stray_load_complete", 32'(load_complete), 32'd0);
                else begin
                    cur_ld = lq.pop_front();
                    check("load_data", load_data, cur_ld);
                end
            end
            if (rv_pending) begin
                if (rv_delay == 0) begin
                    mem_rvalid = 1'b1; mem_rdata = rv_data; rv_pending = 1'b0;
                end else rv_delay--;
            end
            mem_ack = 1'b0;
            if (mem_request && ack_en) begin
                mem_ack = 1'b1;
                if (tq.size() == 0) check("txn_unexpected", 32'(mem_request), 32'd0);
                else begin
                    cur_t = tq.pop_front();
                    check("txn_addr", mem_addr, cur_t.addr);
                    check("txn_rnw", 32'(mem_rnw), 32'(cur_t.rnw));
                    check("txn_be", 32'(mem_be), 32'(cur_t.be));
                    if (!cur_t.rnw) check("txn_wdata", mem_wdata, cur_t.wdata);
                end
                if (mem_rnw) begin
                    rv_pending = 1'b1; rv_delay = rv_extra; rv_data = mem_read(mem_addr);
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", n_errors);
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; new_request = 1'b0; addr = '0; data = '0; fn3 = '0;
        load = 1'b0; store = 1'b0; ack_en = 1'b1; rv_extra = 0;
        mem_model[32'h0000_0100] = 32'h80FF_1122;
        mem_model[32'h0000_0200] = 32'h9ABC_1234;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_lsq_full", 32'(lsq_full), 32'd0);
        check("rst_mem_request", 32'(mem_request), 32'd0);
        check("rst_load_complete", 32'(load_complete), 32'd0);
        check("rst_load_data", load_data, 32'd0);

        // LB sign extension with minimum latency.
        send(1'b1, 3'b000, 32'h103, 32'h0, 1'b1, 1'b1);
        check("lb_issue_req", 32'(mem_request), 32'd1);
        check("lb_issue_addr", mem_addr, 32'h100);
        check("lb_issue_be", 32'(mem_be), 32'hF);
        @(negedge clk);
        check("lb_t2_complete", 32'(load_complete), 32'd0);
        @(negedge clk);
        check("lb_t3_complete", 32'(load_complete), 32'd1);
        check("lb_t3_data", load_data, 32'hFFFF_FF80);
        @(negedge clk);
        check("lb_t4_complete", 32'(load_complete), 32'd0);
        check("lb_t4_hold", load_data, 32'hFFFF_FF80);
        wait_drain();

        // LHU / LH on the upper halfword.
        send(1'b1, 3'b101, 32'h202, 32'h0, 1'b1, 1'b1);
        wait_drain();
        check("lhu_data", load_data, 32'h0000_9ABC);
        send(1'b1, 3'b001, 32'h202, 32'h0, 1'b1, 1'b1);
        wait_drain();
        check("lh_data", load_data, 32'hFFFF_9ABC);

        // Store lanes.
        send(1'b0, 3'b000, 32'h11, 32'h55, 1'b0, 1'b1);
        check("sb_be", 32'(mem_be), 32'b0010);
        check("sb_wdata", mem_wdata, 32'h5555_5555);
        check("sb_rnw", 32'(mem_rnw), 32'd0);
        wait_drain();
        send(1'b0, 3'b001, 32'h12, 32'hBEEF, 1'b0, 1'b1);
        check("sh_be", 32'(mem_be), 32'b1100);
        check("sh_wdata", mem_wdata, 32'hBEEF_BEEF);
        wait_drain();
        check("store_hold_data", load_data, 32'hFFFF_9ABC);

        // Fill with ack held off, drop a request while full, then drain with wrap.
        ack_en = 1'b0;
        send(1'b1, 3'b010, 32'h301, 32'h0, 1'b1, 1'b1);
        send(1'b0, 3'b000, 32'h303, 32'hA1, 1'b0, 1'b1);
        send(1'b1, 3'b100, 32'h306, 32'h0, 1'b1, 1'b1);
        check("fill3_not_full", 32'(lsq_full), 32'd0);
        send(1'b0, 3'b001, 32'h30B, 32'h1234, 1'b0, 1'b1);
        check("fill4_full", 32'(lsq_full), 32'd1);
        addr = 32'h3F0; data = 32'hDEAD_BEEF; fn3 = 3'b010; load = 1'b0; store = 1'b1;
        new_request = 1'b1;
        @(negedge clk);
        new_request = 1'b0;
        check("drop_still_full", 32'(lsq_full), 32'd1);
        @(posedge clk);
        ack_en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            logic [2:0] ftab [6];
            ftab = '{3'b000, 3'b101, 3'b001, 3'b100, 3'b010, 3'b000};
            send(i[0], ftab[i], 32'h400 + 32'(i * 5), 32'h1111_1111 * 32'(i + 1), 1'b1, 1'b1);
        end
        wait_drain();

        // Push while full in the same cycle a load completes.
        ack_en = 1'b0;
        for (int i = 0; i < 4; i++) send(1'b1, 3'b010, 32'h500 + 32'(4 * i), 32'h0, 1'b1, 1'b1);
        check("pp_full", 32'(lsq_full), 32'd1);
        @(posedge clk);
        ack_en = 1'b1;
        @(posedge clk);
        ack_en = 1'b0;
        @(negedge clk);
        check("pp_full_before", 32'(lsq_full), 32'd1);
        send(1'b1, 3'b001, 32'h5F2, 32'h0, 1'b1, 1'b0);
        check("pp_full_after", 32'(lsq_full), 32'd1);
        @(posedge clk);
        ack_en = 1'b1;
        wait_drain();

        // Reset while a load waits for its data; the late rvalid must be ignored.
        rv_extra = 3;
        send(1'b1, 3'b010, 32'h600, 32'h0, 1'b0, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        rv_extra = 0;
        for (int i = 0; i < 6; i++) begin
            check("rstw_load_complete", 32'(load_complete), 32'd0);
            check("rstw_mem_request", 32'(mem_request), 32'd0);
            check("rstw_lsq_full", 32'(lsq_full), 32'd0);
            @(negedge clk);
        end
        send(1'b1, 3'b000, 32'h605, 32'h0, 1'b1, 1'b1);
        wait_drain();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
